// File: rtl/arb_request_agent_if.sv
// rtl/arb_request_agent_if.sv - request/grant and burst-beat bus between arb_request_agent and its peers
//
// Signals:
//   REQUEST1..REQUEST4  agent -> arbiter   registered request lines, one per channel
//   GRANT_I[3:0]        arbiter -> agent   one-hot grant, 4'b1000=ch1 .. 4'b0001=ch4
//   xfer_valid          agent -> consumer  burst beat active
//   xfer_id[1:0]        agent -> consumer  channel of the current burst (0=ch1 .. 3=ch4)
//   xfer_beat[3:0]      agent -> consumer  beat index within the burst
//   xfer_last           agent -> consumer  final beat of the burst
// Modports: master = agent side, slave = arbiter/consumer side.
interface arb_request_agent_if;
    logic       REQUEST1;
    logic       REQUEST2;
    logic       REQUEST3;
    logic       REQUEST4;
    logic [3:0] GRANT_I;
    logic       xfer_valid;
    logic [1:0] xfer_id;
    logic [3:0] xfer_beat;
    logic       xfer_last;

    modport master (
        output REQUEST1, REQUEST2, REQUEST3, REQUEST4,
        output xfer_valid, xfer_id, xfer_beat, xfer_last,
        input  GRANT_I
    );

    modport slave (
        input  REQUEST1, REQUEST2, REQUEST3, REQUEST4,
        input  xfer_valid, xfer_id, xfer_beat, xfer_last,
        output GRANT_I
    );
endinterface

// File: rtl/arb_request_agent.sv
// rtl/arb_request_agent.sv - requester agent: per-channel job counters, request FSMs, burst engine, grant checks
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (synchronous release expected)
//   job_push[3:0] per-channel job post pulse, bit0=ch1 .. bit3=ch4
//   job_full[3:0] per-channel pending counter saturated
//   bus           master side of arb_request_agent_if (REQUESTn, GRANT_I, xfer_*)
//   err_multi     sticky: more than one grant bit seen in a cycle
//   err_spurious  sticky: grant moved to a channel that is idle or in its guard gap
module arb_request_agent #(
    parameter int CNT_W     = 4,
    parameter int BURST_LEN = 4,
    parameter int GAP       = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          job_push,
    output logic [3:0]          job_full,
    arb_request_agent_if.master bus,
    output logic                err_multi,
    output logic                err_spurious
);
    localparam int HW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {CH_IDLE, CH_REQ, CH_XFER, CH_GAP} ch_state_t;

    ch_state_t        ch_state [4];
    ch_state_t        ch_next  [4];
    logic [CNT_W-1:0] pending  [4];
    logic [2:0]       gap_cnt  [4];
    logic [HW-1:0]    hold_cnt [4];
    logic [3:0]       armed;
    logic [3:0]       req_q;

    logic [3:0]       grant_vec;
    logic             grant_onehot;
    logic             grant_multi;
    logic [1:0]       grant_idx;
    logic             accept;

    logic             busy;
    logic [1:0]       eng_id;
    logic [3:0]       beat;
    logic             last_beat;
    logic [3:0]       done;

    // Sampled even while in reset so a grant already sitting on the bus when
    // reset releases does not look like a fresh grant change.
    logic [3:0]       prev_grant;

    // The arbiter numbers grants MSB-first; flip so index i is channel i+1.
    assign grant_vec    = {bus.GRANT_I[0], bus.GRANT_I[1], bus.GRANT_I[2], bus.GRANT_I[3]};
    assign grant_onehot = (grant_vec != 4'd0) && ((grant_vec & (grant_vec - 4'd1)) == 4'd0);
    assign grant_multi  = (grant_vec != 4'd0) && !grant_onehot;

    always_comb begin
        grant_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant_vec[i]) grant_idx = 2'(i);
        end
    end

    assign accept    = !busy && grant_onehot && (ch_state[grant_idx] == CH_REQ) && armed[grant_idx];
    assign last_beat = busy && (beat == 4'(BURST_LEN - 1));

    always_comb begin
        done = '0;
        for (int i = 0; i < 4; i++) begin
            done[i] = last_beat && (eng_id == 2'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ch_next[i] = ch_state[i];
            case (ch_state[i])
                CH_IDLE: if (pending[i] != '0) ch_next[i] = CH_REQ;
                CH_REQ:  if (accept && (grant_idx == 2'(i))) ch_next[i] = CH_XFER;
                CH_XFER: if (done[i]) ch_next[i] = (GAP == 0) ? CH_IDLE : CH_GAP;
                CH_GAP:  if (gap_cnt[i] == 3'(GAP - 1)) ch_next[i] = CH_IDLE;
                default: ch_next[i] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                ch_state[i] <= CH_IDLE;
                pending[i]  <= '0;
                gap_cnt[i]  <= '0;
                hold_cnt[i] <= '0;
            end
            armed <= '0;
            req_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ch_state[i] <= ch_next[i];
                req_q[i]    <= (ch_next[i] == CH_REQ) || (ch_next[i] == CH_XFER);

                // A push landing on the completing beat replaces the finished
                // job, so the count holds even when saturated.
                if (done[i] && !job_push[i]) begin
                    pending[i] <= pending[i] - CNT_W'(1);
                end else if (job_push[i] && !done[i] && (pending[i] != CNT_MAX)) begin
                    pending[i] <= pending[i] + CNT_W'(1);
                end

                gap_cnt[i] <= (ch_state[i] == CH_GAP) ? gap_cnt[i] + 3'd1 : 3'd0;

                // Arming guards against taking a grant that was left asserted
                // from before this request; a low grant bit proves it is fresh,
                // otherwise wait out TIMEOUT cycles of it held high.
                if (ch_state[i] == CH_REQ) begin
                    if (!grant_vec[i]) begin
                        armed[i]    <= 1'b1;
                        hold_cnt[i] <= '0;
                    end else if (hold_cnt[i] == HW'(TIMEOUT - 1)) begin
                        armed[i]    <= 1'b1;
                    end else begin
                        hold_cnt[i] <= hold_cnt[i] + HW'(1);
                    end
                end else begin
                    hold_cnt[i] <= '0;
                    if (done[i]) armed[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            eng_id <= 2'd0;
            beat   <= 4'd0;
        end else if (accept) begin
            busy   <= 1'b1;
            eng_id <= grant_idx;
            beat   <= 4'd0;
        end else if (busy) begin
            if (last_beat) begin
                busy <= 1'b0;
                beat <= 4'd0;
            end else begin
                beat <= beat + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_multi    <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (grant_multi) err_multi <= 1'b1;
            if (grant_onehot && (bus.GRANT_I != prev_grant) &&
                ((ch_state[grant_idx] == CH_IDLE) || (ch_state[grant_idx] == CH_GAP))) begin
                err_spurious <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        prev_grant <= bus.GRANT_I;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            job_full[i] = (pending[i] == CNT_MAX);
        end
    end

    assign bus.REQUEST1   = req_q[0];
    assign bus.REQUEST2   = req_q[1];
    assign bus.REQUEST3   = req_q[2];
    assign bus.REQUEST4   = req_q[3];
    assign bus.xfer_valid = busy;
    assign bus.xfer_id    = busy ? eng_id : 2'd0;
    assign bus.xfer_beat  = beat;
    assign bus.xfer_last  = last_beat;
endmodule
